// File: rtl/film_scanner_pkg.sv
// film_scanner_pkg: shared DAC serial-link defaults and the DAC write FSM state type
package film_scanner_pkg;
    localparam int DAC_FRAME_BITS = 16;
    localparam int DAC_CLK_DIV = 4;
    localparam int DAC_SYNC_GAP = 8;
    localparam int DAC_FIFO_DEPTH = 4;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } dac_state_t;
    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/dac_spi_tx_req_fifo.sv
// req_fifo: first-word-fall-through request buffer, flushed by reset
module req_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] count_q;
    logic do_push, do_pop;
    assign full_o = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign dout_o = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop = pop_i && !empty_o;
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: buffered MSB-first serial write master driving the CCD bias/offset DAC pins
module dac_spi_tx
    import film_scanner_pkg::*;
#(
    parameter int FRAME_BITS = DAC_FRAME_BITS,
    parameter int CLK_DIV    = DAC_CLK_DIV,
    parameter int SYNC_GAP   = DAC_SYNC_GAP,
    parameter int FIFO_DEPTH = DAC_FIFO_DEPTH
) (
    input  logic                  clk_80M_i,
    input  logic                  nrst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [FRAME_BITS-1:0] req_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  dac_sync_o,
    output logic                  dac_sclk_o,
    output logic                  dac_sdin_o
);
    localparam int DW = $clog2(max_int(CLK_DIV, SYNC_GAP) + 1);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int FAW = $clog2(FIFO_DEPTH);
    dac_state_t state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic sync_q, sync_d, sclk_q, sclk_d, sdin_q, sdin_d, done_q, done_d, rdy_q;
    logic div_tc, fifo_pop, fifo_full, fifo_empty;
    logic [FRAME_BITS-1:0] fifo_dout;
    logic [FAW:0] fifo_count;
    req_fifo #(.WIDTH(FRAME_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_80M_i),
        .nrst_i  (nrst_i),
        .push_i  (req_valid_i && req_ready_o),
        .pop_i   (fifo_pop),
        .din_i   (req_data_i),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );
    assign req_ready_o = rdy_q && !fifo_full;
    assign busy_o = (fifo_count != '0) || (state_q != IDLE);
    assign done_o = done_q;
    assign dac_sync_o = sync_q;
    assign dac_sclk_o = sclk_q;
    assign dac_sdin_o = sdin_q;
    assign div_tc = div_q == '0;
    always_comb begin
        state_d = state_q;
        div_d = div_tc ? '0 : div_q - 1'b1;
        bit_d = bit_q;
        shift_d = shift_q;
        sync_d = sync_q;
        sclk_d = sclk_q;
        sdin_d = sdin_q;
        done_d = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty) begin
                fifo_pop = 1'b1;
                shift_d = fifo_dout;
                sync_d = 1'b0;
                sdin_d = fifo_dout[FRAME_BITS-1];
                bit_d = BW'(FRAME_BITS - 1);
                div_d = DW'(CLK_DIV - 1);
                state_d = SETUP;
            end
            SETUP: if (div_tc) begin
                sclk_d = 1'b1;
                div_d = DW'(CLK_DIV - 1);
                state_d = HIGH;
            end
            // falling edge here is where the DAC samples; bit_q counts bits still to follow
            HIGH: if (div_tc) begin
                sclk_d = 1'b0;
                div_d = DW'(CLK_DIV - 1);
                state_d = (bit_q == '0) ? HOLD : LOW;
            end
            LOW: if (div_tc) begin
                sclk_d = 1'b1;
                shift_d = shift_q << 1;
                sdin_d = shift_q[FRAME_BITS-2];
                bit_d = bit_q - 1'b1;
                div_d = DW'(CLK_DIV - 1);
                state_d = HIGH;
            end
            HOLD: if (div_tc) begin
                sync_d = 1'b1;
                sdin_d = 1'b0;
                done_d = 1'b1;
                div_d = DW'(SYNC_GAP - 1);
                state_d = GAP;
            end
            GAP: if (div_tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_80M_i) begin
        if (!nrst_i) begin
            state_q <= IDLE;
            div_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            sync_q <= 1'b1;
            sclk_q <= 1'b0;
            sdin_q <= 1'b0;
            done_q <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q <= div_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            sync_q <= sync_d;
            sclk_q <= sclk_d;
            sdin_q <= sdin_d;
            done_q <= done_d;
            rdy_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed checks of framing, buffering, reset abort and a small-parameter build
module tb_dac_spi_tx;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic a_valid = 1'b0, b_valid = 1'b0;
    logic [15:0] a_data = '0;
    logic [23:0] b_data = '0;
    logic a_ready, a_busy, a_done, a_sync, a_sclk, a_sdin;
    logic b_ready, b_busy, b_done, b_sync, b_sclk, b_sdin;
    int tests = 0, fails = 0, ncyc = 0, acc_n = 0, lat_acc = 0;
    int cdiv [2] = '{4, 1};
    logic [1:0] p_sync = 2'b11, p_sclk = 2'b00, p_sdin = 2'b00;
    logic [1:0] m_sync, m_sclk, m_sdin, m_done;
    int ff_n [2], fall_n [2], rise_n [2], chg_n [2], lf_n [2];
    int nf [2], nfr [2], ngap [2], dn [2], dbad [2], sbad [2];
    logic [31:0] cap [2];
    logic [31:0] words [2][8];
    int lows [2][8], falls [2][8], gaps [2][8];
    logic [15:0] bw [6] = '{16'h1357, 16'h2468, 16'hF00F, 16'h0FF0, 16'h5AA5, 16'hC001};
    logic [15:0] edge_w [3] = '{16'h0000, 16'hFFFF, 16'h8001};
    logic [23:0] sw_w [3] = '{24'hC3A50F, 24'h000001, 24'h800000};

    dac_spi_tx u_a (
        .clk_80M_i(clk), .nrst_i(nrst), .req_valid_i(a_valid), .req_ready_o(a_ready),
        .req_data_i(a_data), .busy_o(a_busy), .done_o(a_done), .dac_sync_o(a_sync),
        .dac_sclk_o(a_sclk), .dac_sdin_o(a_sdin)
    );
    dac_spi_tx #(.FRAME_BITS(24), .CLK_DIV(1), .SYNC_GAP(1), .FIFO_DEPTH(2)) u_b (
        .clk_80M_i(clk), .nrst_i(nrst), .req_valid_i(b_valid), .req_ready_o(b_ready),
        .req_data_i(b_data), .busy_o(b_busy), .done_o(b_done), .dac_sync_o(b_sync),
        .dac_sclk_o(b_sclk), .dac_sdin_o(b_sdin)
    );

    always #5 clk = ~clk;

    assign m_sync = {b_sync, a_sync};
    assign m_sclk = {b_sclk, a_sclk};
    assign m_sdin = {b_sdin, a_sdin};
    assign m_done = {b_done, a_done};

    // DAC-side model: samples pins once per cycle on the falling clk edge
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (m_sync[i] && !p_sync[i]) begin
                if (nfr[i] < 8) begin
                    lows[i][nfr[i]] = ncyc - fall_n[i];
                    words[i][nfr[i]] = cap[i];
                    falls[i][nfr[i]] = nf[i];
                end
                nfr[i] = nfr[i] + 1;
                rise_n[i] = ncyc;
                if (!m_done[i]) dbad[i] = dbad[i] + 1;
            end
            if (!m_sync[i] && p_sync[i]) begin
                if (nfr[i] == 0) ff_n[i] = ncyc;
                if (rise_n[i] != 0 && ngap[i] < 8) begin
                    gaps[i][ngap[i]] = ncyc - rise_n[i];
                    ngap[i] = ngap[i] + 1;
                end
                fall_n[i] = ncyc;
                cap[i] = '0;
                nf[i] = 0;
            end
            if (!m_sclk[i] && p_sclk[i]) begin
                cap[i] = {cap[i][30:0], m_sdin[i]};
                nf[i] = nf[i] + 1;
                if (ncyc - chg_n[i] < cdiv[i]) sbad[i] = sbad[i] + 1;
                lf_n[i] = ncyc;
            end
            if (m_sdin[i] != p_sdin[i]) begin
                if (lf_n[i] != 0 && ncyc - lf_n[i] < cdiv[i]) sbad[i] = sbad[i] + 1;
                chg_n[i] = ncyc;
            end
            if (m_done[i] && !(m_sync[i] && !p_sync[i])) dbad[i] = dbad[i] + 1;
            if (m_done[i]) dn[i] = dn[i] + 1;
        end
        p_sync = m_sync;
        p_sclk = m_sclk;
        p_sdin = m_sdin;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon(input int i);
        nfr[i] = 0;
        ngap[i] = 0;
        dn[i] = 0;
        dbad[i] = 0;
        rise_n[i] = 0;
        ff_n[i] = 0;
    endtask

    task automatic push(input int i, input logic [31:0] d);
        int t = 0;
        if (i == 0) begin a_valid = 1'b1; a_data = d[15:0]; end
        else begin b_valid = 1'b1; b_data = d[23:0]; end
        while (((i == 0) ? !a_ready : !b_ready) && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        check("push_ready", 32'(t < 2000), 32'd1);
        @(posedge clk);
        acc_n = ncyc;
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data = 16'hDEAD;
        b_data = 24'hBEEF00;
    endtask

    task automatic wait_frames(input int i, input int n, input int bound);
        int t = 0;
        while (nfr[i] < n && t < bound) begin @(posedge clk); #1; t++; end
        check("frames_seen", 32'(nfr[i]), 32'(n));
    endtask

    task automatic wait_sync_low();
        int t = 0;
        while (a_sync && t < 20) begin @(posedge clk); #1; t++; end
        check("sync_low_seen", 32'(a_sync), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_sync", 32'(a_sync), 32'd1);
        check("rst_sclk", 32'(a_sclk), 32'd0);
        check("rst_sdin", 32'(a_sdin), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_ready", 32'(a_ready), 32'd0);
        nrst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", 32'(a_ready), 32'd1);
        repeat (1000) @(posedge clk);
        #1;
        check("idle_sync", 32'(a_sync), 32'd1);
        check("idle_sclk", 32'(a_sclk), 32'd0);
        check("idle_sdin", 32'(a_sdin), 32'd0);
        check("idle_busy", 32'(a_busy), 32'd0);
        check("idle_ready", 32'(a_ready), 32'd1);
        check("idle_ready_b", 32'(b_ready), 32'd1);
        clear_mon(0);
        clear_mon(1);
        // single frame
        push(0, 32'hA5C3);
        check("busy_after_accept", 32'(a_busy), 32'd1);
        lat_acc = acc_n;
        wait_frames(0, 1, 400);
        repeat (12) @(posedge clk);
        #1;
        check("single_latency", 32'(ff_n[0] - lat_acc), 32'd2);
        check("single_low", 32'(lows[0][0]), 32'd132);
        check("single_word", words[0][0], 32'hA5C3);
        check("single_falls", 32'(falls[0][0]), 32'd16);
        check("single_done_count", 32'(dn[0]), 32'd1);
        check("single_done_shape", 32'(dbad[0]), 32'd0);
        check("single_busy_end", 32'(a_busy), 32'd0);
        // burst of six with FIFO backpressure
        clear_mon(0);
        push(0, 32'(bw[0]));
        wait_sync_low();
        for (int k = 1; k < 5; k++) push(0, 32'(bw[k]));
        check("burst_ready_full", 32'(a_ready), 32'd0);
        push(0, 32'(bw[5]));
        wait_frames(0, 6, 2000);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("burst_word%0d", k), words[0][k], 32'(bw[k]));
            check($sformatf("burst_low%0d", k), 32'(lows[0][k]), 32'd132);
            check($sformatf("burst_falls%0d", k), 32'(falls[0][k]), 32'd16);
        end
        check("burst_gap_count", 32'(ngap[0]), 32'd5);
        for (int k = 0; k < 5; k++) check($sformatf("burst_gap%0d", k), 32'(gaps[0][k]), 32'd9);
        check("burst_done_count", 32'(dn[0]), 32'd6);
        // boundary patterns
        repeat (12) @(posedge clk);
        #1;
        clear_mon(0);
        for (int k = 0; k < 3; k++) push(0, 32'(edge_w[k]));
        wait_frames(0, 3, 1200);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("edge_word%0d", k), words[0][k], 32'(edge_w[k]));
            check($sformatf("edge_falls%0d", k), 32'(falls[0][k]), 32'd16);
        end
        check("sdin_stability_a", 32'(sbad[0]), 32'd0);
        check("done_shape_a", 32'(dbad[0]), 32'd0);
        // reset in the middle of a frame with two words queued
        repeat (12) @(posedge clk);
        #1;
        clear_mon(0);
        push(0, 32'h1234);
        wait_sync_low();
        push(0, 32'h4321);
        push(0, 32'h7777);
        for (int t = 0; t < 200 && nf[0] < 7; t++) begin @(posedge clk); #1; end
        check("abort_at_bit7", 32'(nf[0]), 32'd7);
        nrst = 1'b0;
        @(posedge clk); #1;
        check("abort_sync", 32'(a_sync), 32'd1);
        check("abort_sclk", 32'(a_sclk), 32'd0);
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_ready", 32'(a_ready), 32'd0);
        nrst = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("abort_no_done", 32'(dn[0]), 32'd0);
        check("abort_fifo_flushed", 32'(nfr[0]), 32'd1);
        check("abort_idle_busy", 32'(a_busy), 32'd0);
        clear_mon(0);
        push(0, 32'h5A96);
        wait_frames(0, 1, 400);
        check("post_abort_word", words[0][0], 32'h5A96);
        check("post_abort_low", 32'(lows[0][0]), 32'd132);
        check("post_abort_done", 32'(dn[0]), 32'd1);
        // small-parameter build
        clear_mon(1);
        push(1, 32'(sw_w[0]));
        lat_acc = acc_n;
        push(1, 32'(sw_w[1]));
        push(1, 32'(sw_w[2]));
        wait_frames(1, 3, 600);
        repeat (5) @(posedge clk);
        #1;
        check("sweep_latency", 32'(ff_n[1] - lat_acc), 32'd2);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("sweep_word%0d", k), words[1][k], 32'(sw_w[k]));
            check($sformatf("sweep_low%0d", k), 32'(lows[1][k]), 32'd49);
            check($sformatf("sweep_falls%0d", k), 32'(falls[1][k]), 32'd24);
        end
        check("sweep_gap_count", 32'(ngap[1]), 32'd2);
        for (int k = 0; k < 2; k++) check($sformatf("sweep_gap%0d", k), 32'(gaps[1][k]), 32'd2);
        check("sweep_done_count", 32'(dn[1]), 32'd3);
        check("sweep_done_shape", 32'(dbad[1]), 32'd0);
        check("sdin_stability_b", 32'(sbad[1]), 32'd0);
        check("sweep_busy_end", 32'(b_busy), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
